alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Issue/writeback controller on the requesting side of the ALU interface: drives `enable` and `instr` into the ALU and consumes `alu_result`/`zero_flag`.
- Accepts R-type ALU instructions over a valid/ready handshake and presents each to the ALU for exactly one cycle.
- Captures result and zero flag, then returns them, tagged with rd, on a valid/ready writeback channel.
- Sits between decode and register-file writeback in the execute stage.

Parameters:
- RESULT_W, 32, width of ALU result and writeback data.
- RD_W, 5, width of destination register index.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  controller can accept an instruction this cycle.
- in_instr  input  32  instruction_t from decode.
- alu_enable  output  1  to ALU enable.
- alu_instr  output  32  instruction_t to ALU.
- alu_result  input  RESULT_W  from ALU (combinational).
- alu_zero  input  1  zero_flag from ALU.
- wb_valid  output  1  writeback record valid.
- wb_ready  input  1  downstream accepts record.
- wb_rd  output  RD_W  destination register (instr.r.rd).
- wb_data  output  RESULT_W  captured result.
- wb_zero  output  1  captured zero flag.
- wb_we  output  1  register write enable; 0 when rd==0 or illegal.
- wb_illegal  output  1  instruction matched no M_* pattern.

Behaviour:
- Reset values: state IDLE; in_ready=1; alu_enable=0; alu_instr=0; wb_valid=0; wb_rd=0; wb_data=0; wb_zero=0; wb_we=0; wb_illegal=0.
- FSM states: IDLE, EXEC, WB.
  - IDLE: in_ready=1. On in_valid, latch in_instr → EXEC.
  - EXEC: alu_enable=1, alu_instr=latched instr, in_ready=0. At the clock edge, register wb_data←alu_result, wb_zero←alu_zero, wb_rd←instr.r.rd, wb_illegal←!legal, wb_we←legal && rd!=0. → WB.
  - WB: wb_valid=1; all wb_* outputs stable until handshake. in_ready = wb_ready.
    - wb_ready && in_valid: record retires, new instr latched, → EXEC (back-to-back).
    - wb_ready && !in_valid: → IDLE.
    - !wb_ready: stay in WB.
- Latency: accept at edge N; alu_enable high in cycle N+1; wb_valid high from cycle N+2. Throughput 1 instruction per 2 cycles.
- alu_enable is asserted only in EXEC; alu_instr is driven 0 outside EXEC.
- Legality is decoded from the latched instr against M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_SLT, M_SLTU (casez).
  - Illegal ops still pass through EXEC so timing is uniform.
  - For illegal ops, wb_data = ILLEGAL_RESULT (32'hDEADBEEF), taken from the package constant rather than the ALU; wb_zero=0; wb_we=0; wb_illegal=1.
- rd==0 on a legal op: record still emitted, wb_we=0.
- in_valid while in EXEC: ignored (in_ready=0); upstream must hold the instruction.
- Reset asserted in any state: next edge forces reset values; an in-flight instruction or record is discarded with no wb_valid pulse.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined: adds output ports perf_issued[31:0] and perf_illegal[31:0]. perf_issued increments on each EXEC cycle; perf_illegal increments on each EXEC cycle with an illegal op. Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared opcodes package:
  - instruction_t and M_* patterns (existing).
  - New: alu_issue_state_t enum {IDLE, EXEC, WB} and localparam ILLEGAL_RESULT = 32'hDEADBEEF.
- One sub-module, alu_op_legal: combinational; instruction_t in, legal bit out; casez over M_* patterns.
- FSM and writeback registers live in alu_issue_ctrl.

Test Plan:
- Single ADD, rd=5, ALU model returns 32'h0000_0007: alu_enable high exactly in cycle N+1; cycle N+2 shows wb_valid=1, wb_rd=5, wb_data=7, wb_zero=0, wb_we=1, wb_illegal=0.
- SUB, rd=0, ALU returns 0: wb_zero=1, wb_we=0, wb_valid=1.
- Opcode 32'hFFFF_FFFF: wb_illegal=1, wb_data=32'hDEADBEEF, wb_we=0; with ALU_ISSUE_PERF_EN, perf_illegal=1 and perf_issued=1.
- wb_ready held low 4 cycles with in_valid high: wb_* outputs stable, in_ready=0, alu_enable stays low; when wb_ready rises, next instruction is accepted that same cycle and alu_enable pulses the following cycle.
- Ten back-to-back ops with wb_ready=1: ten wb_valid pulses, every other cycle, in order, rd values matching.
- reset asserted during EXEC: next cycle state IDLE, wb_valid=0, in_ready=1; the dropped instruction produces no record.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode definitions for the execute-stage ALU issue path.
// R-type instruction layout, ALU op match patterns, issue FSM states.
package alu_issue_ctrl_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef union packed {
    logic [31:0] raw;
    r_type_t     r;
  } instruction_t;

  localparam logic [31:0] M_ADD  = 32'b0000000_?????_?????_000_?????_0110011;
  localparam logic [31:0] M_SUB  = 32'b0100000_?????_?????_000_?????_0110011;
  localparam logic [31:0] M_SLL  = 32'b0000000_?????_?????_001_?????_0110011;
  localparam logic [31:0] M_SLT  = 32'b0000000_?????_?????_010_?????_0110011;
  localparam logic [31:0] M_SLTU = 32'b0000000_?????_?????_011_?????_0110011;
  localparam logic [31:0] M_XOR  = 32'b0000000_?????_?????_100_?????_0110011;
  localparam logic [31:0] M_SRL  = 32'b0000000_?????_?????_101_?????_0110011;
  localparam logic [31:0] M_SRA  = 32'b0100000_?????_?????_101_?????_0110011;
  localparam logic [31:0] M_OR   = 32'b0000000_?????_?????_110_?????_0110011;
  localparam logic [31:0] M_AND  = 32'b0000000_?????_?????_111_?????_0110011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } alu_issue_state_t;

  localparam logic [31:0] ILLEGAL_RESULT = 32'hDEADBEEF;

endpackage

// File: rtl/alu_op_legal.sv
// Combinational legality check of an instruction against the
// supported R-type ALU op patterns.
module alu_op_legal
  import alu_issue_ctrl_pkg::*;
(
  input  instruction_t instr_i,
  output logic         legal_o
);

  // Match against every supported ALU op; anything else is illegal.
  always_comb begin
    legal_o = 1'b0;
    casez (instr_i.raw)
      M_ADD, M_SUB, M_AND, M_OR, M_XOR,
      M_SLL, M_SRL, M_SRA, M_SLT, M_SLTU: legal_o = 1'b1;
      default:                            legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/writeback controller: one cycle of ALU issue per instruction,
// result returned on a valid/ready writeback channel. Optional counters: ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int RESULT_W = 32,
  parameter int RD_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  instruction_t        in_instr,
  output logic                alu_enable,
  output instruction_t        alu_instr,
  input  logic [RESULT_W-1:0] alu_result,
  input  logic                alu_zero,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RD_W-1:0]     wb_rd,
  output logic [RESULT_W-1:0] wb_data,
  output logic                wb_zero,
  output logic                wb_we,
  output logic                wb_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_illegal
`endif
);

  alu_issue_state_t    state_q, state_d;
  instruction_t        instr_q;
  logic                legal;
  logic                accept;
  logic                in_exec;
  logic [RD_W-1:0]     wb_rd_q;
  logic [RESULT_W-1:0] wb_data_q;
  logic                wb_zero_q;
  logic                wb_we_q;
  logic                wb_illegal_q;

  alu_op_legal u_legal (
    .instr_i (instr_q),
    .legal_o (legal)
  );

  // Next state and upstream ready; WB frees the slot only on retire.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        in_ready = wb_ready;
        if (wb_ready) state_d = in_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign in_exec    = (state_q == EXEC);
  assign alu_enable = in_exec;
  assign alu_instr  = in_exec ? instr_q : '0;
  assign wb_valid   = (state_q == WB);
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_zero    = wb_zero_q;
  assign wb_we      = wb_we_q;
  assign wb_illegal = wb_illegal_q;

  // State, instruction latch, and writeback capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_zero_q    <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= in_instr;
      if (in_exec) begin
        wb_rd_q      <= RD_W'(instr_q.r.rd);
        wb_data_q    <= legal ? alu_result
                              : RESULT_W'(ILLEGAL_RESULT);
        wb_zero_q    <= legal && alu_zero;
        wb_we_q      <= legal && (instr_q.r.rd != 5'd0);
        wb_illegal_q <= !legal;
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_illegal_q;

  // Saturating counts of issued and illegal EXEC cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q  <= '0;
      perf_illegal_q <= '0;
    end else if (in_exec) begin
      if (perf_issued_q != '1)
        perf_issued_q <= perf_issued_q + 32'd1;
      if (!legal && perf_illegal_q != '1)
        perf_illegal_q <= perf_illegal_q + 32'd1;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_illegal = perf_illegal_q;
`else
  // Counters not built; nothing extra to drive.
`endif

endmodule
